// File: rtl/input_vc_controller_pkg.sv
// Shared definitions for the per-VC input controller.
//   N / V          : router output-port count and VC count per port
//   FT_*           : two-bit flit type codes carried in the flit's top bits
//   ivc_state_e    : packet-sequencing FSM state encoding (2 bits)
//   is_head_type / is_tail_type : flit type classification helpers
package input_vc_controller_pkg;

    localparam int N = 5;
    localparam int V = 4;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROUTING  = 2'd1,
        ST_VC_ALLOC = 2'd2,
        ST_ACTIVE   = 2'd3
    } ivc_state_e;

    // Head and single both open a packet.
    function automatic logic is_head_type(input logic [1:0] t);
        return (t == FT_HEAD) || (t == FT_SINGLE);
    endfunction

    // Tail and single both close a packet.
    function automatic logic is_tail_type(input logic [1:0] t);
        return (t == FT_TAIL) || (t == FT_SINGLE);
    endfunction

endpackage

// File: rtl/input_vc_controller_ivc_fifo.sv
// ivc_fifo: circular flit buffer.
//   push/din   : write request and data (accepted when not full, or when
//                a pop happens in the same cycle)
//   pop        : read request (ignored while empty)
//   dout       : head entry, combinational; undefined while empty
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module ivc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 34
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/input_vc_controller.sv
// input_vc_controller: per-(input port, VC) front end of the router.
// Buffers link flits, presents the head destination to route computation,
// registers the route, then walks the packet through VC and switch
// allocation, returning one credit upstream per forwarded flit.
//   inFlit/inValid             : flit write from the link
//   creditOut                  : registered one-cycle credit per popped flit
//   dst                        : head flit destination, to rc
//   candidateOutPort/VC        : route result from rc
//   vaReq/vaReqPort/vaReqVC    : VC allocation request and registered route
//   vaGrant/vaGrantVC          : VC allocation result
//   saReq/saGrant              : switch allocation request/grant (grant pops)
//   outFlit/outValid           : head flit and its switch-traversal strobe
//   outPort/outVC              : route and VC held for the current packet
//   errOverflow                : sticky, a write arrived while full
//   fsmState                   : current sequencing state, for observation
// Handshake: saGrant pops only in ACTIVE with data buffered; outValid is
// that same qualified grant, combinational, and creditOut follows it by
// exactly one cycle. vaGrant counts only while vaReq is high.
module input_vc_controller
    import input_vc_controller_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 34
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [FLIT_W-1:0] inFlit,
    input  logic              inValid,
    output logic              creditOut,
    output logic [7:0]        dst,
    input  logic [N-1:0]      candidateOutPort,
    input  logic [V-1:0]      candidateOutVC,
    output logic              vaReq,
    output logic [N-1:0]      vaReqPort,
    output logic [V-1:0]      vaReqVC,
    input  logic              vaGrant,
    input  logic [V-1:0]      vaGrantVC,
    output logic              saReq,
    input  logic              saGrant,
    output logic [FLIT_W-1:0] outFlit,
    output logic              outValid,
    output logic [N-1:0]      outPort,
    output logic [V-1:0]      outVC,
    output logic              errOverflow,
    output ivc_state_e        fsmState
);

    ivc_state_e                 state;
    ivc_state_e                 state_nx;
    logic [FLIT_W-1:0]          head_flit;
    logic [1:0]                 head_type;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic                       pop;

    ivc_fifo #(
        .DEPTH (DEPTH),
        .W     (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inValid),
        .pop   (pop),
        .din   (inFlit),
        .dout  (head_flit),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_type = head_flit[FLIT_W-1:FLIT_W-2];
    assign dst       = head_flit[7:0];
    assign outFlit   = head_flit;
    assign fsmState  = state;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next state. A non-head flit at the head in IDLE simply stalls here.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (!fifo_empty && is_head_type(head_type)) state_nx = ST_ROUTING;
            ST_ROUTING:  state_nx = ST_VC_ALLOC;
            ST_VC_ALLOC: if (vaGrant) state_nx = ST_ACTIVE;
            ST_ACTIVE:   if (pop && is_tail_type(head_type)) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        vaReq    = 1'b0;
        saReq    = 1'b0;
        pop      = 1'b0;
        outValid = 1'b0;
        case (state)
            ST_VC_ALLOC: vaReq = 1'b1;
            ST_ACTIVE: begin
                saReq    = (fifo_count != '0);
                pop      = saGrant && !fifo_empty;
                outValid = pop;
            end
            default: ;
        endcase
    end

    // Route/VC registers, credit return and overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vaReqPort   <= '0;
            vaReqVC     <= '0;
            outPort     <= '0;
            outVC       <= '0;
            creditOut   <= 1'b0;
            errOverflow <= 1'b0;
        end else begin
            if (state == ST_ROUTING) begin
                vaReqPort <= candidateOutPort;
                vaReqVC   <= candidateOutVC;
                outPort   <= candidateOutPort;
            end
            if (state == ST_VC_ALLOC && vaGrant) begin
                outVC <= vaGrantVC;
            end
            creditOut <= pop;
            // The write is dropped by the buffer; only a simultaneous pop makes room.
            if (inValid && fifo_full && !pop) begin
                errOverflow <= 1'b1;
            end
        end
    end

endmodule
